// File: rtl/elegant_regfile.sv
// DEPTH x WIDTH register file with a lane-masked write port, a registered read port,
// per-entry valid bits, a live occupancy count and a one-cycle invalidate-all.

module elegant_regfile_lane #(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] old_lane,
  input  logic [LANE_W-1:0] new_lane,
  input  logic              en,
  output logic [LANE_W-1:0] merged_lane
);
  assign merged_lane = en ? new_lane : old_lane;
endmodule

module elegant_regfile #(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 3,
  parameter bit BYPASS = 1'b1,
  localparam int LANES = WIDTH / LANE_W,
  localparam int DEPTH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [LANES-1:0]  wr_mask,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              clr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_ack,
  output logic              rd_vld,
  output logic [ADDR_W:0]   occupancy
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [ADDR_W:0]             occ_q, occ_d;
  logic [WIDTH-1:0]            rd_data_q, rd_data_d;
  logic                        rd_ack_q, rd_ack_d;
  logic                        rd_vld_q, rd_vld_d;

  logic                        wr_hit;
  logic [WIDTH-1:0]            wr_base;
  logic [WIDTH-1:0]            wr_merged;

  // Invalid entries contribute zeros to a partial write, so stale bits left
  // behind by clr never resurface once the entry becomes valid again.
  assign wr_hit  = wr_en && (|wr_mask);
  assign wr_base = valid_q[wr_addr] ? mem_q[wr_addr] : '0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    elegant_regfile_lane #(.LANE_W(LANE_W)) u_lane (
      .old_lane   (wr_base[i*LANE_W +: LANE_W]),
      .new_lane   (wr_data[i*LANE_W +: LANE_W]),
      .en         (wr_mask[i]),
      .merged_lane(wr_merged[i*LANE_W +: LANE_W])
    );
  end

  always_comb begin
    mem_d   = mem_q;
    valid_d = clr ? '0 : valid_q;
    if (wr_hit) begin
      mem_d[wr_addr]   = wr_merged;
      valid_d[wr_addr] = 1'b1;
    end

    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + {{ADDR_W{1'b0}}, valid_d[i]};
    end

    rd_ack_d  = rd_en;
    rd_data_d = rd_data_q;
    rd_vld_d  = rd_vld_q;
    if (rd_en) begin
      if (BYPASS && wr_hit && (wr_addr == rd_addr)) begin
        rd_data_d = wr_merged;
        rd_vld_d  = 1'b1;
      end else begin
        rd_data_d = valid_q[rd_addr] ? mem_q[rd_addr] : '0;
        rd_vld_d  = valid_q[rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q     <= '0;
      valid_q   <= '0;
      occ_q     <= '0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      valid_q   <= valid_d;
      occ_q     <= occ_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_ack    = rd_ack_q;
  assign rd_vld    = rd_vld_q;
  assign occupancy = occ_q;

endmodule

// File: doc/elegant_regfile.md
Name: elegant_regfile

Overview:
- Parametrised successor to the single-word 8-bit storage cell.
- Holds DEPTH words of WIDTH bits, with one lane-masked write port and one registered read port.
- Tracks a valid bit per entry, keeps a live occupancy count, and supports a one-cycle invalidate-all.
- Serves as the general-purpose small storage block for datapath scratch and configuration shadowing.

Parameters:
- WIDTH, 16: data word width in bits. Must be a multiple of LANE_W.
- LANE_W, 8: write-mask granularity in bits. LANES = WIDTH/LANE_W.
- ADDR_W, 3: address width. DEPTH = 2**ADDR_W.
- BYPASS, 1: 1 = a same-cycle same-address read returns the merged new data; 0 = it returns the old contents.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- wr_mask  in  LANES  per-lane write enable; bit i covers bits [i*LANE_W +: LANE_W]
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  read address
- clr  in  1  invalidate all entries
- rd_data  out  WIDTH  registered read data
- rd_ack  out  1  one-cycle pulse, read result present
- rd_vld  out  1  addressed entry was valid at the read
- occupancy  out  ADDR_W+1  number of valid entries

Behaviour:
- Single clock domain. All state updates on the rising edge of clk.
- Reset (rst=1 at an edge):
  - All words = 0, all valid bits = 0.
  - rd_data = 0, rd_ack = 0, rd_vld = 0, occupancy = 0.
  - rst overrides every other input in that cycle, including an in-flight read: no rd_ack follows.
- Write (wr_en=1):
  - Only lanes with wr_mask[i]=1 are updated; the other lanes keep their old value.
  - The entry's valid bit is set iff wr_mask != 0.
  - wr_en=1 with wr_mask=0 is a no-op.
- Read (rd_en=1 in cycle N):
  - In cycle N+1: rd_ack=1; rd_vld = entry valid; rd_data = entry word if valid, else 0.
  - rd_en=0: rd_ack=0 next cycle; rd_data and rd_vld hold their last values.
  - Back-to-back reads give one result per cycle. Latency is fixed at 1 cycle; there is no backpressure.
- Read sees the pre-edge state. The only exception is the same-cycle same-address write:
  - BYPASS=1: rd_data = merged word (masked lanes from wr_data, other lanes from the old word, with old lanes treated as 0 if the entry was invalid). rd_vld = old valid OR (wr_mask != 0).
  - BYPASS=0: old word and old valid bit are returned.
- clr=1:
  - All valid bits cleared at the edge. Stored data bits are retained but unreadable, because invalid entries read as 0.
  - clr together with a write: the write wins for its entry (entry valid after the edge, occupancy = 1 if mask != 0, else 0).
  - clr together with a read: the read reports pre-clr state (plus bypass per BYPASS).
- occupancy:
  - Registered; equals the population count of the valid bits after each edge.
  - Rewriting an already-valid entry does not change it.
  - Maximum value DEPTH (needs ADDR_W+1 bits); no wrap.
- Address range: every ADDR_W value is legal; there are no out-of-range cases.

Test Plan:
- Reset then a read at each address 0..7 → every rd_ack=1, rd_vld=0, rd_data=0x0000, occupancy=0.
- Write addr 3 = 0xA55A (mask 2'b11); next cycle write addr 3 = 0x12FF (mask 2'b01); read addr 3 → rd_data=0xA5FF, rd_vld=1, occupancy=1.
- Same-cycle write addr 5 = 0xBEEF (mask 11) with read addr 5 on an empty table → BYPASS=1: 0xBEEF, rd_vld=1; BYPASS=0: 0x0000, rd_vld=0.
- Fill all 8 entries → occupancy=8; then clr together with write addr 2 = 0x0102 (mask 11) → occupancy=1; read addr 2 = 0x0102, read addr 4 = 0x0000 with rd_vld=0.
- Write with mask 2'b00 to addr 6 → occupancy unchanged; read addr 6 gives rd_vld=0.
- Issue rd_en addr 1 (valid), then assert rst in the next cycle → no rd_ack after reset, all outputs 0.
